matrix_operand_loader: RTL and testbench

- Upstream feeder for the 2x2 parallel matrix multiplier.
- Accepts a byte stream of operand elements over a valid/ready handshake and assembles two packed 2x2 matrices.
- A is received first, then B, each in row-major order.
- Presents both matrices as stable 32-bit words with a valid/ready handshake; each accepted frame is one operand pair for the multiplier's a/b inputs.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_operand_loader.sv | 118 +++++++++++
 tb/tb_matrix_operand_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the 2x2 matrix datapath: element/word widths, loader
// state encoding, and the row-major packing order used by the multiplier too.
package matrix_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ELEM = 4;
    localparam int MAT_W  = ELEM_W * N_ELEM;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // Row-major packing: element 0 (x00) lands in the top byte, element 3 (x11) in the bottom.
    function automatic logic [MAT_W-1:0] put_elem(input logic [MAT_W-1:0] word,
                                                  input logic [1:0]       idx,
                                                  input logic [ELEM_W-1:0] elem);
        logic [MAT_W-1:0] w;
        w = word;
        w[(N_ELEM - 1 - int'(idx)) * ELEM_W +: ELEM_W] = elem;
        return w;
    endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// Assembles a byte stream (A row-major, then B row-major) into two packed 2x2
// matrices and hands the pair to the multiplier over a valid/ready handshake.
module matrix_operand_loader
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ELEM_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_sof,
    output logic              in_ready,
    output logic [MAT_W-1:0]  a_out,
    output logic [MAT_W-1:0]  b_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err_sof,
    output logic [7:0]        frame_cnt,
    output state_t            state
);

    // Handshakes: a byte moves on a rising edge where in_valid && in_ready; a
    // frame moves where out_valid && out_ready. Neither ready depends on the
    // matching valid, and the source must hold its data until it is taken.

    state_t           state_nxt;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic [MAT_W-1:0] a_nxt;
    logic [MAT_W-1:0] b_nxt;
    logic             in_ready_nxt;
    logic             out_valid_nxt;
    logic             err_nxt;
    logic [7:0]       frame_nxt;
    logic             xfer;
    logic             restart;

    assign xfer    = in_valid && in_ready;
    // in_sof only counts as an error when it interrupts a frame already begun.
    assign restart = xfer && in_sof && !(state == LOAD_A && cnt == 2'd0);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        a_nxt         = a_out;
        b_nxt         = b_out;
        out_valid_nxt = out_valid;
        err_nxt       = 1'b0;
        frame_nxt     = frame_cnt;

        if (restart) begin
            a_nxt     = put_elem(a_out, 2'd0, in_data);
            state_nxt = LOAD_A;
            cnt_nxt   = 2'd1;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                LOAD_A: begin
                    if (xfer) begin
                        a_nxt   = put_elem(a_out, cnt, in_data);
                        cnt_nxt = cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state_nxt = LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        b_nxt   = put_elem(b_out, cnt, in_data);
                        cnt_nxt = cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state_nxt     = PRESENT;
                            out_valid_nxt = 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (out_valid && out_ready) begin
                        state_nxt     = LOAD_A;
                        cnt_nxt       = 2'd0;
                        out_valid_nxt = 1'b0;
                        frame_nxt     = frame_cnt + 8'd1;
                    end
                end
                default: begin
                    state_nxt     = LOAD_A;
                    cnt_nxt       = 2'd0;
                    out_valid_nxt = 1'b0;
                end
            endcase
        end

        // Registered ready: closed exactly while a frame is being presented.
        in_ready_nxt = (state_nxt != PRESENT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD_A;
            cnt       <= 2'd0;
            a_out     <= '0;
            b_out     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            err_sof   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            a_out     <= a_nxt;
            b_out     <= b_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            err_sof   <= err_nxt;
            frame_cnt <= frame_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Bench for matrix_operand_loader: byte-stream driver, byte-level reference
// model feeding an expected-frame queue, and a negedge monitor that checks it.
`timescale 1ns/1ps
module tb_matrix_operand_loader;
    import matrix_pkg::*;

    localparam int CLK_P = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #(CLK_P/2) clk = ~clk;

    logic [7:0]  in_data  = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_sof   = 1'b0;
    logic        in_ready;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic        out_valid;
    logic        out_ready;
    logic        err_sof;
    logic [7:0]  frame_cnt;
    state_t      dut_state;

    bit   rdy_rand  = 1'b0;
    logic rdy_fixed = 1'b1;
    logic rnd_rdy   = 1'b0;
    assign out_ready = rdy_rand ? rnd_rdy : rdy_fixed;

    always @(posedge clk) begin
        #1;
        rnd_rdy = 1'($urandom_range(0, 1));
    end

    matrix_operand_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_ready  (in_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_sof   (err_sof),
        .frame_cnt (frame_cnt),
        .state     (dut_state)
    );

    // ---------------- scoreboard state ----------------
    logic [63:0] exp_q[$];     // {A, B} as the concatenation of the 8 accepted bytes
    logic [7:0]  mdl_buf[$];   // bytes of the frame currently being assembled
    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_exp  = 0;
    int          err_seen = 0;
    logic [7:0]  deliv    = 8'd0;
    bit          prev_hs  = 1'b0;
    bit          prev_ov  = 1'b0;
    time         first_t  = 0;
    time         rise_t   = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a frame is simply the next 8 accepted bytes; an in_sof on
    // any byte other than the first of a frame throws away what came before.
    task automatic model_accept(input logic [7:0] d, input logic sof);
        logic [63:0] f;
        f = '0;
        if (sof && mdl_buf.size() != 0) begin
            err_exp++;
            mdl_buf.delete();
        end
        mdl_buf.push_back(d);
        if (mdl_buf.size() == 1) first_t = $time;
        if (mdl_buf.size() == 8) begin
            for (int i = 0; i < 8; i++) f = {f[55:0], mdl_buf[i]};
            exp_q.push_back(f);
            mdl_buf.delete();
        end
    endtask

    // ---------------- driver tasks (enter/leave at posedge+1) ----------------
    task automatic send_byte(input logic [7:0] d, input logic sof, input int gap);
        int  n;
        bit  took;
        n    = 0;
        took = 1'b0;
        in_data  = d;
        in_sof   = sof;
        in_valid = 1'b1;
        while (!took && n < 200) begin
            @(negedge clk);
            if (in_ready) took = 1'b1;
            else          n++;
        end
        if (took) model_accept(d, sof);
        else      check_eq("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [63:0] f, input int gap);
        for (int i = 0; i < 8; i++) send_byte(f[63 - 8*i -: 8], i == 0, gap);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check_eq("rst_a_out", 64'(a_out), 64'd0);
        check_eq("rst_b_out", 64'(b_out), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_err_sof", 64'(err_sof), 64'd0);
        check_eq("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        check_eq("rst_state", 64'(dut_state), 64'd0);
        exp_q.delete();
        mdl_buf.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        check_eq("in_ready_after_edge", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            deliv   = 8'd0;
            prev_hs = 1'b0;
            prev_ov = 1'b0;
        end else begin
            if (prev_hs) begin
                check_eq("out_valid_one_cycle", 64'(out_valid), 64'd0);
                check_eq("in_ready_reopen", 64'(in_ready), 64'd1);
                check_eq("frame_cnt", 64'(frame_cnt), 64'(deliv));
            end
            if (out_valid && !prev_ov) rise_t = $time;
            if (err_sof) err_seen++;
            if (out_valid) begin
                check_eq("in_ready_closed", 64'(in_ready), 64'd0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_frame", 64'(exp_q.size()), 64'd1);
                end else begin
                    check_eq("a_out", 64'(a_out), 64'(exp_q[0][63:32]));
                    check_eq("b_out", 64'(b_out), 64'(exp_q[0][31:0]));
                end
                if (out_ready) begin
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    deliv++;
                end
            end
            prev_hs = out_valid && out_ready;
            prev_ov = out_valid;
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int e0;
        logic [63:0] f;

        do_reset();

        // Continuous frame, consumer always ready.
        rdy_fixed = 1'b1;
        send_frame(64'h0102030405060708, 0);
        wait_idle();
        check_eq("latency_continuous", 64'((rise_t - first_t) / CLK_P), 64'd8);
        check_eq("frame_cnt_first", 64'(frame_cnt), 64'd1);
        check_eq("err_none", 64'(err_seen), 64'd0);

        // Consumer stalls; a byte offered meanwhile must not be taken.
        rdy_fixed = 1'b0;
        send_frame(64'h0102030405060708, 0);
        in_data  = 8'hFF;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rdy_fixed = 1'b1;
        wait_idle();

        // Mid-frame restart by in_sof.
        e0 = err_seen;
        send_byte(8'h11, 1'b1, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h0A, 1'b1, 0);
        for (int i = 0; i < 7; i++) send_byte(8'(8'h0B + i), 1'b0, 0);
        wait_idle();
        check_eq("err_restart_pulses", 64'(err_seen - e0), 64'd1);

        // One idle cycle between bytes.
        send_frame(64'h0102030405060708, 1);
        wait_idle();
        check_eq("latency_gapped", 64'((rise_t - first_t) / CLK_P), 64'd15);

        // Reset mid-frame loses the partial frame and clears the count.
        for (int i = 0; i < 6; i++) send_byte(8'(i + 1), i == 0, 0);
        do_reset();
        send_frame(64'h2122232425262728, 0);
        wait_idle();
        check_eq("frame_cnt_after_reset", 64'(frame_cnt), 64'd1);

        // 256 back-to-back frames wrap the counter.
        do_reset();
        for (int k = 0; k < 256; k++) begin
            f = {$urandom(), $urandom()};
            send_frame(f, 0);
        end
        wait_idle();
        check_eq("frame_cnt_wrap", 64'(frame_cnt), 64'd0);
        f = {$urandom(), $urandom()};
        send_frame(f, 0);
        wait_idle();
        check_eq("frame_cnt_after_wrap", 64'(frame_cnt), 64'd1);

        // Random stream: random bytes, gaps, restarts and consumer stalls.
        rdy_rand = 1'b1;
        for (int k = 0; k < 320; k++) begin
            send_byte(8'($urandom()), $urandom_range(0, 9) == 0, $urandom_range(0, 2));
        end
        while (mdl_buf.size() != 0) send_byte(8'($urandom()), 1'b0, 0);
        wait_idle();
        rdy_rand = 1'b0;

        check_eq("err_total", 64'(err_seen), 64'(err_exp));
        check_eq("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
